// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op constants plus the multiply/divide
// operation and FSM state encodings used by muldiv_unit.
package cpu_pkg;

  // ALU op constants
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;

  // Multiply/divide operation select (matches the op port encoding)
  typedef enum logic [1:0] {
    MULLO = 2'b00,
    MULHI = 2'b01,
    DIV   = 2'b10,
    REM   = 2'b11
  } muldiv_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } muldiv_state_e;

  localparam int unsigned MULDIV_W     = 16;
  localparam logic [4:0]  MULDIV_LAST  = 5'd15;

endpackage

// File: rtl/muldiv_unit_if.sv
// Bundle of the muldiv_unit request/response signals.
//   master: drives operands, op and start; observes busy/done/result/flags
//   slave : the unit side
interface muldiv_unit_if;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [1:0]  op;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        V;
  logic        N;
  logic        Z;
  logic        DZ;

  modport master (
    output a_in, b_in, op, start,
    input  busy, done, result, V, N, Z, DZ
  );

  modport slave (
    input  a_in, b_in, op, start,
    output busy, done, result, V, N, Z, DZ
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
//   is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   opnd   : multiplicand (multiply) or divisor (divide)
//   hi/lo  : working registers. Multiply: {hi,lo} accumulates the product,
//            lo starts as the multiplier. Divide: hi is the partial
//            remainder, lo shifts the dividend out and the quotient in.
module muldiv_step (
  input  logic        is_div,
  input  logic [15:0] opnd,
  input  logic [15:0] hi_in,
  input  logic [15:0] lo_in,
  output logic [15:0] hi_out,
  output logic [15:0] lo_out
);

  logic [16:0] sum;
  logic [16:0] trial;

  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    sum    = '0;
    trial  = '0;
    if (is_div) begin
      // Remainder is always < divisor, so the trial fits in 17 bits and the
      // restored value always fits back into 16.
      trial  = {hi_in, lo_in[15]};
      lo_out = {lo_in[14:0], 1'b0};
      if (trial >= {1'b0, opnd}) begin
        trial     = trial - {1'b0, opnd};
        lo_out[0] = 1'b1;
      end
      hi_out = trial[15:0];
    end else begin
      sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : 17'd0);
      hi_out = sum[16:1];
      lo_out = {sum[0], lo_in[15:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide unit.
//   clk, rst_n      : clock, asynchronous active-low reset
//   a_in, b_in, op  : operands and op (MULLO/MULHI/DIV/REM), taken on start
//   start           : request, accepted only while idle
//   busy            : iterating
//   done            : one-cycle pulse when result/flags update
//   result, V,N,Z,DZ: registered result and flags, held until next done
module muldiv_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [1:0]  op,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        V,
  output logic        N,
  output logic        Z,
  output logic        DZ
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [15:0]   opnd_q, opnd_d;
  logic [15:0]   hi_q, hi_d;
  logic [15:0]   lo_q, lo_d;
  logic [15:0]   result_q, result_d;
  logic          v_q, v_d;
  logic          dz_q, dz_d;
  logic          done_q, done_d;

  logic          is_div;
  logic [15:0]   step_hi;
  logic [15:0]   step_lo;

  assign is_div = (op_q == DIV) || (op_q == REM);

  muldiv_step u_step (
    .is_div (is_div),
    .opnd   (opnd_q),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    v_d      = v_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          op_d    = muldiv_op_e'(op);
          cnt_d   = '0;
          hi_d    = '0;
          // op[1] selects divide: divisor in opnd, dividend shifted via lo
          opnd_d  = op[1] ? b_in : a_in;
          lo_d    = op[1] ? a_in : b_in;
        end
      end
      BUSY: begin
        if (is_div && (opnd_q == '0)) begin
          // Divide by zero finishes after one busy cycle; lo still holds a_in
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = (op_q == DIV) ? '1 : lo_q;
          v_d      = 1'b0;
          dz_d     = 1'b1;
        end else begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == MULDIV_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dz_d    = 1'b0;
            v_d     = 1'b0;
            unique case (op_q)
              MULLO: begin
                result_d = step_lo;
                v_d      = |step_hi;
              end
              MULHI:   result_d = step_hi;
              DIV:     result_d = step_lo;
              default: result_d = step_hi;
            endcase
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= MULLO;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      v_q      <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      v_q      <= v_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign done   = done_q;
  assign result = result_q;
  assign V      = v_q;
  assign N      = result_q[15];
  assign Z      = (result_q == '0);
  assign DZ     = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed expectations.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  muldiv_unit_if mif ();

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_in   (mif.a_in),
    .b_in   (mif.b_in),
    .op     (mif.op),
    .start  (mif.start),
    .busy   (mif.busy),
    .done   (mif.done),
    .result (mif.result),
    .V      (mif.V),
    .N      (mif.N),
    .Z      (mif.Z),
    .DZ     (mif.DZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request now and count edges (from the accepting edge) until done.
  // Optionally pulse a conflicting start mid-operation. Result must not move
  // before done.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                       input bit poke, output int lat);
    logic [15:0] held;
    bit held_ok;
    held    = mif.result;
    held_ok = 1'b1;
    lat     = 0;
    mif.a_in  = a;
    mif.b_in  = b;
    mif.op    = o;
    mif.start = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        mif.start = 1'b0;
        check("busy_after_start", 32'(mif.busy), 32'd1);
      end
      if (poke && lat == 5) begin
        mif.a_in  = 16'hFFFF;
        mif.b_in  = 16'hFFFF;
        mif.op    = 2'b01;
        mif.start = 1'b1;
      end
      if (poke && lat == 6) mif.start = 1'b0;
      if (!mif.done && mif.result !== held) held_ok = 1'b0;
    end while (!mif.done && lat < 40);
    check("result_held", 32'(held_ok), 32'd1);
  endtask

  task automatic op_test(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] o, input logic [15:0] exp_r, input logic exp_v,
                         input logic exp_dz, input int exp_lat);
    int lat;
    do_op(a, b, o, 1'b0, lat);
    check({tag, ":lat"},    32'(lat),        32'(exp_lat));
    check({tag, ":result"}, 32'(mif.result), 32'(exp_r));
    check({tag, ":V"},      32'(mif.V),      32'(exp_v));
    check({tag, ":N"},      32'(mif.N),      32'(exp_r[15]));
    check({tag, ":Z"},      32'(mif.Z),      32'(exp_r == 16'h0000));
    check({tag, ":DZ"},     32'(mif.DZ),     32'(exp_dz));
    check({tag, ":idle"},   32'(mif.busy),   32'd0);
    @(posedge clk);
    #1;
    check({tag, ":done_pulse"}, 32'(mif.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat;
    bit  nodone;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    mif.a_in  = '0;
    mif.b_in  = '0;
    mif.op    = 2'b00;
    mif.start = 1'b0;

    #7;
    check("rst:busy",   32'(mif.busy),   32'd0);
    check("rst:done",   32'(mif.done),   32'd0);
    check("rst:result", 32'(mif.result), 32'd0);
    check("rst:V",      32'(mif.V),      32'd0);
    check("rst:N",      32'(mif.N),      32'd0);
    check("rst:Z",      32'(mif.Z),      32'd1);
    check("rst:DZ",     32'(mif.DZ),     32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op_test("mullo_1234x10", 16'h1234, 16'h0010, 2'b00, 16'h2340, 1'b1, 1'b0, 17);
    op_test("mulhi_1234x10", 16'h1234, 16'h0010, 2'b01, 16'h0001, 1'b0, 1'b0, 17);
    op_test("mulhi_ffffsq",  16'hFFFF, 16'hFFFF, 2'b01, 16'hFFFE, 1'b0, 1'b0, 17);
    op_test("mullo_ffffsq",  16'hFFFF, 16'hFFFF, 2'b00, 16'h0001, 1'b1, 1'b0, 17);
    op_test("div_100_7",     16'h0064, 16'h0007, 2'b10, 16'h000E, 1'b0, 1'b0, 17);
    op_test("rem_100_7",     16'h0064, 16'h0007, 2'b11, 16'h0002, 1'b0, 1'b0, 17);
    op_test("div_by0",       16'h1234, 16'h0000, 2'b10, 16'hFFFF, 1'b0, 1'b1, 2);
    op_test("rem_by0",       16'h1234, 16'h0000, 2'b11, 16'h1234, 1'b0, 1'b1, 2);
    op_test("div_a_lt_b",    16'h0005, 16'h0009, 2'b10, 16'h0000, 1'b0, 1'b0, 17);
    op_test("rem_a_lt_b",    16'h0005, 16'h0009, 2'b11, 16'h0005, 1'b0, 1'b0, 17);
    op_test("div_by1",       16'hABCD, 16'h0001, 2'b10, 16'hABCD, 1'b0, 1'b0, 17);
    op_test("rem_by1",       16'hABCD, 16'h0001, 2'b11, 16'h0000, 1'b0, 1'b0, 17);
    op_test("mullo_zero",    16'h0000, 16'hBEEF, 2'b00, 16'h0000, 1'b0, 1'b0, 17);

    // Start pulse while busy must not disturb the operation in flight
    do_op(16'h1234, 16'h0010, 2'b00, 1'b1, lat);
    check("poke:lat",    32'(lat),        32'd17);
    check("poke:result", 32'(mif.result), 32'h2340);
    check("poke:V",      32'(mif.V),      32'd1);
    @(posedge clk);
    #1;
    check("poke:done_pulse", 32'(mif.done), 32'd0);

    // Back-to-back: second start issued in the done cycle of the first
    do_op(16'h0064, 16'h0007, 2'b10, 1'b0, lat);
    check("b2b1:lat",    32'(lat),        32'd17);
    check("b2b1:result", 32'(mif.result), 32'h000E);
    do_op(16'hFFFF, 16'hFFFF, 2'b01, 1'b0, lat);
    check("b2b2:lat",    32'(lat),        32'd17);
    check("b2b2:result", 32'(mif.result), 32'hFFFE);
    check("b2b2:N",      32'(mif.N),      32'd1);
    @(posedge clk);
    #1;

    // Leave a nonzero result, then reset mid-operation
    op_test("pre_rst", 16'h1234, 16'h0000, 2'b11, 16'h1234, 1'b0, 1'b1, 2);
    nodone    = 1'b1;
    mif.a_in  = 16'h0005;
    mif.b_in  = 16'h0007;
    mif.op    = 2'b00;
    mif.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) mif.start = 1'b0;
      if (k == 5) mif.start = 1'b1;
      if (k == 6) mif.start = 1'b0;
      if (mif.done) nodone = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst:nodone", 32'(nodone),     32'd1);
    check("midrst:busy",   32'(mif.busy),   32'd0);
    check("midrst:done",   32'(mif.done),   32'd0);
    check("midrst:result", 32'(mif.result), 32'd0);
    check("midrst:Z",      32'(mif.Z),      32'd1);
    check("midrst:DZ",     32'(mif.DZ),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0003, 16'h0000, 2'b00, 1'b0, lat);
    check("postrst:lat",    32'(lat),        32'd17);
    check("postrst:result", 32'(mif.result), 32'd0);
    check("postrst:Z",      32'(mif.Z),      32'd1);
    check("postrst:V",      32'(mif.V),      32'd0);
    check("postrst:DZ",     32'(mif.DZ),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
